mdu_unit: RTL and testbench

Multiply/divide unit with architectural HI/LO registers. It sits beside the Execute stage of the 5-stage MIPS pipeline and is fed from the forwarded rs/rt operands. It models multi-cycle latency with a busy counter that the hazard unit uses to stall D→E. It also serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_calc.sv | 62 ++++++
 rtl/mdu_unit.sv | 103 ++++++++++
 tb/tb_mdu_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op encodings and default constants for the MIPS
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int MDU_XLEN        = 32;
    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    function automatic logic is_muldiv(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// Module      : mdu_calc
// Description : Combinational multiply/divide datapath producing {hi,lo}
//               and a divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_calc
    import mdu_pkg::*;
(
    input  mdu_op_e                 op,
    input  logic [MDU_XLEN-1:0]     rs,
    input  logic [MDU_XLEN-1:0]     rt,
    output logic [2*MDU_XLEN-1:0]   result,
    output logic                    div0
);

    logic                   w_signed_op;
    logic                   w_is_div;
    logic [2*MDU_XLEN-1:0]  w_a64;
    logic [2*MDU_XLEN-1:0]  w_b64;
    logic [2*MDU_XLEN-1:0]  w_prod;
    logic [MDU_XLEN-1:0]    w_rs_mag;
    logic [MDU_XLEN-1:0]    w_rt_mag;
    logic [MDU_XLEN-1:0]    w_divisor;
    logic [MDU_XLEN-1:0]    w_q_mag;
    logic [MDU_XLEN-1:0]    w_r_mag;
    logic                   w_q_neg;
    logic                   w_r_neg;

    assign w_signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_div    = (op == OP_DIV) || (op == OP_DIVU);

    // The low 64 bits of a 64x64 product are correct for both signednesses
    // once the operands are sign- or zero-extended appropriately.
    assign w_a64  = {{MDU_XLEN{w_signed_op & rs[MDU_XLEN-1]}}, rs};
    assign w_b64  = {{MDU_XLEN{w_signed_op & rt[MDU_XLEN-1]}}, rt};
    assign w_prod = w_a64 * w_b64;

    // Magnitude division avoids the INT_MIN / -1 overflow; negating
    // 0x80000000 wraps back to itself, giving the required result.
    assign w_rs_mag  = (w_signed_op && rs[MDU_XLEN-1]) ? -rs : rs;
    assign w_rt_mag  = (w_signed_op && rt[MDU_XLEN-1]) ? -rt : rt;
    assign div0      = w_is_div && (rt == '0);
    assign w_divisor = (rt == '0) ? {{(MDU_XLEN-1){1'b0}}, 1'b1} : w_rt_mag;
    assign w_q_mag   = w_rs_mag / w_divisor;
    assign w_r_mag   = w_rs_mag % w_divisor;
    assign w_q_neg   = w_signed_op && (rs[MDU_XLEN-1] ^ rt[MDU_XLEN-1]);
    assign w_r_neg   = w_signed_op && rs[MDU_XLEN-1];

    always_comb begin
        result = '0;
        case (op)
            OP_MULT, OP_MULTU: result = w_prod;
            OP_DIV, OP_DIVU:   result = {(w_r_neg ? -w_r_mag : w_r_mag),
                                         (w_q_neg ? -w_q_mag : w_q_mag)};
            default:           result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit
// Description : Multi-cycle multiply/divide unit with architectural HI/LO,
//               busy counter and MFHI/MFLO/MTHI/MTLO support.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  mdu_op_e             op,
    input  logic [MDU_XLEN-1:0] rs_val,
    input  logic [MDU_XLEN-1:0] rt_val,
    output logic                busy,
    output logic                start,
    output logic [MDU_XLEN-1:0] rd_data,
    output logic [MDU_XLEN-1:0] hi,
    output logic [MDU_XLEN-1:0] lo
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_busy;
    logic [MDU_XLEN-1:0]     r_hi;
    logic [MDU_XLEN-1:0]     r_lo;
    logic [MDU_XLEN-1:0]     r_shadow_hi;
    logic [MDU_XLEN-1:0]     r_shadow_lo;
    logic                    r_shadow_wr;
    logic [2*MDU_XLEN-1:0]   w_result;
    logic                    w_div0;
    logic                    w_is_div;

    mdu_calc u_calc (
        .op     (op),
        .rs     (rs_val),
        .rt     (rt_val),
        .result (w_result),
        .div0   (w_div0)
    );

    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_shadow_hi <= '0;
            r_shadow_lo <= '0;
            r_shadow_wr <= 1'b0;
        end else if (r_busy) begin
            // Anything issued while busy is dropped; the pipeline stalls it.
            if (r_cnt == c_cnt_w'(1)) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
                if (r_shadow_wr) begin
                    r_hi <= r_shadow_hi;
                    r_lo <= r_shadow_lo;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end else if (op_valid) begin
            case (op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    r_shadow_hi <= w_result[2*MDU_XLEN-1:MDU_XLEN];
                    r_shadow_lo <= w_result[MDU_XLEN-1:0];
                    r_shadow_wr <= !w_div0;
                    r_cnt       <= w_is_div ? c_cnt_w'(DIV_CYCLES) : c_cnt_w'(MULT_CYCLES);
                    r_busy      <= 1'b1;
                end
                OP_MTHI: r_hi <= rs_val;
                OP_MTLO: r_lo <= rs_val;
                default: ;
            endcase
        end
    end

    assign start = op_valid && is_muldiv(op);
    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

    always_comb begin
        rd_data = '0;
        case (op)
            OP_MFHI: rd_data = r_hi;
            OP_MFLO: rd_data = r_lo;
            default: rd_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_unit
// Description : Directed and randomized self-checking bench for mdu_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        op_valid = 1'b0;
    mdu_op_e     op       = OP_NONE;
    logic [31:0] rs_val   = '0;
    logic [31:0] rt_val   = '0;
    logic        busy;
    logic        start;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp     = 0;
    int          n_err     = 0;
    int          n_illegal = 0;
    logic [31:0] m_hi      = '0;
    logic [31:0] m_lo      = '0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .start    (start),
        .rd_data  (rd_data),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Hazard-contract monitor: counts issues presented while busy.
    always @(posedge clk) begin
        if (reset && op_valid && busy)
            n_illegal = n_illegal + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural effect of one accepted op.
    task automatic model(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        longint      sq;
        longint      sr;
        logic [63:0] up;
        case (o)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            OP_MULTU: begin
                up = 64'(a) * 64'(b);
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            OP_DIV: if (b != 0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                m_lo = sq[31:0];
                m_hi = sr[31:0];
            end
            OP_DIVU: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b);
        int n;
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        #1;
        check("start", {31'd0, start}, {31'd0, is_muldiv(o)});
        tick();
        op_valid = 1'b0;
        op       = OP_NONE;
        model(o, a, b);
        if (is_muldiv(o)) begin
            n = ((o == OP_DIV) || (o == OP_DIVU)) ? 10 : 5;
            for (int k = 0; k < n; k++) begin
                check("busy_run", {31'd0, busy}, 32'd1);
                tick();
            end
        end
        check("busy_done", {31'd0, busy}, 32'd0);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic read_mf(input mdu_op_e o, input logic [31:0] exp);
        op_valid = 1'b1;
        op       = o;
        #1;
        check("rd_data", rd_data, exp);
        check("mf_busy", {31'd0, busy}, 32'd0);
        tick();
        op_valid = 1'b0;
        op       = OP_NONE;
    endtask

    initial begin
        int          cyc;
        mdu_op_e     ro;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        repeat (2) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        #2 reset = 1'b1;
        tick();

        // Reset mid-MULT aborts the operation
        op_valid = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4;
        tick();
        op_valid = 1'b0; op = OP_NONE;
        tick();
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        #2 reset = 1'b1;
        repeat (8) tick();
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        // Directed arithmetic
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        check("mult_hi_lit", hi, 32'hFFFF_FFFF);
        check("mult_lo_lit", lo, 32'hFFFF_FFFE);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi_lit", hi, 32'h0000_0001);
        check("multu_lo_lit", lo, 32'hFFFF_FFFE);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_hi_lit", hi, 32'hFFFF_FFFF);
        check("div_lo_lit", lo, 32'hFFFF_FFFD);
        run_op(OP_DIVU, 32'd7, 32'd2);
        check("divu_hi_lit", hi, 32'd1);
        check("divu_lo_lit", lo, 32'd3);

        // MT then MF
        run_op(OP_MTHI, 32'h1234_5678, 32'd0);
        read_mf(OP_MFHI, 32'h1234_5678);
        run_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        read_mf(OP_MFLO, 32'h9ABC_DEF0);
        check("hi_after_mtlo", hi, 32'h1234_5678);

        // Divide by zero leaves HI/LO untouched
        run_op(OP_MTHI, 32'h0000_AAAA, 32'd0);
        run_op(OP_MTLO, 32'h0000_5555, 32'd0);
        run_op(OP_DIV, 32'd100, 32'd0);
        check("div0_hi_lit", hi, 32'h0000_AAAA);
        check("div0_lo_lit", lo, 32'h0000_5555);

        // Signed overflow wraps
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_hi_lit", hi, 32'd0);
        check("ovf_lo_lit", lo, 32'h8000_0000);

        // Op presented while busy is ignored
        op_valid = 1'b1; op = OP_MULT; rs_val = 32'd6; rt_val = 32'd7;
        tick();
        op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd3;
        tick();
        op_valid = 1'b0; op = OP_NONE;
        model(OP_MULT, 32'd6, 32'd7);
        cyc = 1;
        while (busy && cyc < 50) begin
            tick();
            cyc++;
        end
        check("ign_busy_cycles", cyc, 32'd5);
        check("ign_illegal_seen", n_illegal, 32'd1);
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd42);
        check("ign_lo_model", lo, m_lo);

        // Randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0: ro = OP_MULT;
                1: ro = OP_MULTU;
                2: ro = OP_DIV;
                3: ro = OP_DIVU;
                4: ro = OP_MTHI;
                default: ro = OP_MTLO;
            endcase
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 17));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb);
        end
        read_mf(OP_MFHI, m_hi);
        read_mf(OP_MFLO, m_lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
